// File: rtl/tsc_pkg.sv
// Shared types and constants for the TSC capture/readout sequencer.
package tsc_pkg;

  localparam int TSC_BYTE_W     = 8;
  localparam int TSC_NBYTES_DEF = 32;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TRIG_TO = 2'd1;
  localparam logic [1:0] ERR_XFER_TO = 2'd2;
  localparam logic [1:0] ERR_FRAME   = 2'd3;

  // HUNT and DATA live inside tsc_rx_deser; the sequencer sees both as ST_RECV.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_PREP      = 4'd1,
    ST_ARM       = 4'd2,
    ST_WAIT_TRIG = 4'd3,
    ST_SEND      = 4'd4,
    ST_RECV      = 4'd5,
    ST_WAIT_CD   = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERROR     = 4'd8
  } tsc_state_e;

endpackage

// File: rtl/tsc_sequencer_if.sv
// Link between the sequencer (master) and the TSC device (slave).
interface tsc_sequencer_if;

  logic reset;
  logic start;
  logic sbf;
  logic trd;
  logic cd;
  logic sd;

  modport master (
    output reset, start, sbf,
    input  trd, cd, sd
  );

  modport slave (
    input  reset, start, sbf,
    output trd, cd, sd
  );

endinterface

// File: rtl/tsc_rx_deser.sv
// Serial-to-byte deserialiser: hunts for a 0 start bit, then shifts 8 data bits MSB first.
module tsc_rx_deser
  import tsc_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  sd,
  output logic [TSC_BYTE_W-1:0] data,
  output logic                  vld
);

  logic                  in_data_q;
  logic [2:0]            bit_cnt_q;
  logic [TSC_BYTE_W-2:0] shift_q;

  // Dropping en discards any partial frame, so abort/cd/timeout never yield a strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_data_q <= 1'b0;
      bit_cnt_q <= 3'd7;
      shift_q   <= '0;
      data      <= '0;
      vld       <= 1'b0;
    end else begin
      vld <= 1'b0;
      if (!en) begin
        in_data_q <= 1'b0;
        bit_cnt_q <= 3'd7;
      end else if (!in_data_q) begin
        if (!sd) begin
          in_data_q <= 1'b1;
          bit_cnt_q <= 3'd7;
        end
      end else begin
        shift_q <= {shift_q[TSC_BYTE_W-3:0], sd};
        if (bit_cnt_q == 3'd0) begin
          data      <= {shift_q, sd};
          vld       <= 1'b1;
          in_data_q <= 1'b0;
        end else begin
          bit_cnt_q <= bit_cnt_q - 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/tsc_sequencer.sv
// Runs one TSC trigger/readout cycle per cmd_arm, with timeouts, abort and error codes.
// Define TSC_SEQ_CHECKSUM_EN to enable the running XOR checksum on chk.
module tsc_sequencer
  import tsc_pkg::*;
#(
  parameter int  NBYTES       = TSC_NBYTES_DEF,
  parameter int  TRIG_TIMEOUT = 1000000,
  parameter int  XFER_TIMEOUT = 4096,
  parameter int  START_GAP    = 2,
  localparam int IDX_W        = $clog2(NBYTES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_arm,
  input  logic                  cmd_abort,
  tsc_sequencer_if.master       tsc,
  output logic [TSC_BYTE_W-1:0] byte_data,
  output logic                  byte_valid,
  output logic [IDX_W-1:0]      byte_idx,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err,
  output logic [TSC_BYTE_W-1:0] chk
);

  localparam int CNT_W  = $clog2(NBYTES) + 1;
  localparam int TRIG_W = $clog2(TRIG_TIMEOUT) + 1;
  localparam int XFER_W = $clog2(XFER_TIMEOUT) + 1;
  localparam int GAP_W  = $clog2(START_GAP) + 1;

  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [TRIG_W-1:0] LAST_TRIG = TRIG_W'(TRIG_TIMEOUT - 1);
  localparam logic [XFER_W-1:0] LAST_XFER = XFER_W'(XFER_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(START_GAP - 1);

  tsc_state_e            state_q, state_d;
  logic [1:0]            err_q, err_d;
  logic [GAP_W-1:0]      gap_cnt_q;
  logic [TRIG_W-1:0]     trig_cnt_q;
  logic [XFER_W-1:0]     xfer_cnt_q;
  logic [CNT_W-1:0]      byte_cnt_q;
  logic                  rx_en;
  logic                  rx_vld;
  logic [TSC_BYTE_W-1:0] rx_data;
  logic                  parked;
  logic                  arm_acc;
  logic                  xfer_expired;

  assign parked       = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
  assign arm_acc      = cmd_arm && parked;
  assign xfer_expired = (xfer_cnt_q == LAST_XFER);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (cmd_arm) begin
          state_d = ST_PREP;
          err_d   = ERR_NONE;
        end
      end
      ST_PREP: begin
        if (gap_cnt_q == LAST_GAP) state_d = ST_ARM;
      end
      ST_ARM: state_d = ST_WAIT_TRIG;
      ST_WAIT_TRIG: begin
        if (tsc.trd) begin
          state_d = ST_SEND;
        end else if (trig_cnt_q == LAST_TRIG) begin
          state_d = ST_ERROR;
          err_d   = ERR_TRIG_TO;
        end
      end
      ST_SEND: state_d = ST_RECV;
      ST_RECV: begin
        if (tsc.cd) begin
          state_d = ST_ERROR;
          err_d   = ERR_FRAME;
        end else if (xfer_expired) begin
          state_d = ST_ERROR;
          err_d   = ERR_XFER_TO;
        end else if (rx_vld && (byte_cnt_q == LAST_BYTE)) begin
          state_d = ST_WAIT_CD;
        end
      end
      ST_WAIT_CD: begin
        if (tsc.cd) begin
          state_d = ST_DONE;
        end else if (xfer_expired) begin
          state_d = ST_ERROR;
          err_d   = ERR_XFER_TO;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides every other event in a busy state and leaves err untouched.
    if (cmd_abort && !parked) begin
      state_d = ST_IDLE;
      err_d   = err_q;
    end
  end

  // The deserialiser only runs while the sequencer stays in RECV across the edge.
  assign rx_en = (state_q == ST_RECV) && (state_d == ST_RECV);

  tsc_rx_deser u_rx (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (rx_en),
    .sd      (tsc.sd),
    .data    (rx_data),
    .vld     (rx_vld)
  );

  // Each counter only advances in its own state and that state exits at the last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      err_q      <= ERR_NONE;
      gap_cnt_q  <= '0;
      trig_cnt_q <= '0;
      xfer_cnt_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      gap_cnt_q  <= (state_q == ST_PREP) ? gap_cnt_q + 1'b1 : '0;
      trig_cnt_q <= (state_q == ST_WAIT_TRIG) ? trig_cnt_q + 1'b1 : '0;
      xfer_cnt_q <= ((state_q == ST_RECV) || (state_q == ST_WAIT_CD)) ? xfer_cnt_q + 1'b1 : '0;
      if (arm_acc) begin
        byte_cnt_q <= '0;
      end else if ((state_q == ST_RECV) && rx_vld) begin
        byte_cnt_q <= byte_cnt_q + 1'b1;
      end
    end
  end

  assign tsc.reset  = parked;
  assign tsc.start  = (state_q == ST_ARM);
  assign tsc.sbf    = (state_q == ST_SEND);
  assign busy       = !parked;
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign byte_data  = rx_data;
  assign byte_valid = rx_vld;
  assign byte_idx   = byte_cnt_q[IDX_W-1:0];

`ifdef TSC_SEQ_CHECKSUM_EN
  logic [TSC_BYTE_W-1:0] chk_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_q <= '0;
    end else if (arm_acc) begin
      chk_q <= '0;
    end else if (rx_vld) begin
      chk_q <= chk_q ^ rx_data;
    end
  end

  assign chk = chk_q;
`else
  assign chk = '0;
`endif

endmodule

// File: tb/tb_tsc_sequencer.sv
// Randomised self-checking bench for tsc_sequencer with an in-bench TSC and readout model.
module tb_tsc_sequencer;
  import tsc_pkg::*;

  localparam int NB    = 32;
  localparam int TT    = 100;
  localparam int XT    = 512;
  localparam int SG    = 2;
  localparam int IW    = $clog2(NB);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_arm = 1'b0;
  logic          cmd_abort = 1'b0;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic [IW-1:0] byte_idx;
  logic          busy;
  logic          done;
  logic [1:0]    err;
  logic [7:0]    chk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_sbf    = 0;
  logic [7:0] rx_data_q[$];
  int         rx_idx_q[$];

  tsc_sequencer_if tsc_bus ();

  tsc_sequencer #(
    .NBYTES       (NB),
    .TRIG_TIMEOUT (TT),
    .XFER_TIMEOUT (XT),
    .START_GAP    (SG)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_arm    (cmd_arm),
    .cmd_abort  (cmd_abort),
    .tsc        (tsc_bus),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_idx   (byte_idx),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .chk        (chk)
  );

  always #5 clk = ~clk;

  // Sole writer of the pulse counters and received-byte log.
  always @(negedge clk) begin
    if (reset_n) begin
      if (tsc_bus.start) n_start++;
      if (tsc_bus.sbf) n_sbf++;
      if (byte_valid) begin
        rx_data_q.push_back(byte_data);
        rx_idx_q.push_back(int'(byte_idx));
      end
    end
  end

  function automatic logic [7:0] exp_chk(input logic [7:0] b[$], input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++) x ^= b[i];
`ifndef TSC_SEQ_CHECKSUM_EN
    x = 8'h00;
`endif
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    tsc_bus.sd = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b);
    tsc_bus.sd = 1'b0;
    tick();
    for (int i = 7; i >= 0; i--) begin
      tsc_bus.sd = b[i];
      tick();
    end
    tsc_bus.sd = 1'b1;
  endtask

  // Arm, answer the start pulse with trd, and stop in the SEND cycle.
  task automatic start_cycle(input int trd_delay, output bit ok);
    ok = 1'b0;
    cmd_arm = 1'b1; tick(); cmd_arm = 1'b0;
    for (int i = 0; i < SG + 4 && !tsc_bus.start; i++) tick();
    if (!tsc_bus.start) return;
    cmd_arm = 1'b1; tick(); cmd_arm = 1'b0;
    repeat (trd_delay) tick();
    tsc_bus.trd = 1'b1; tick(); tsc_bus.trd = 1'b0;
    for (int i = 0; i < 4 && !tsc_bus.sbf; i++) tick();
    ok = tsc_bus.sbf;
  endtask

  task automatic capture(input logic [7:0] bytes[$], input int n_cd, input int max_gap, output bit ok);
    bit s;
    start_cycle(50, s);
    ok = s;
    if (!s) return;
    for (int k = 0; k < n_cd && k < bytes.size(); k++) begin
      idle(k == 0 ? 1 : int'($urandom_range(0, max_gap)));
      send_frame(bytes[k]);
    end
    idle(3);
    tsc_bus.cd = 1'b1; tick(); tsc_bus.cd = 1'b0;
    idle(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({tsc_bus.reset, tsc_bus.start, tsc_bus.sbf, byte_valid, busy, done} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 100000",
        {tsc_bus.reset, tsc_bus.start, tsc_bus.sbf, byte_valid, busy, done});
    end
    n_checks++;
    if ({byte_data, byte_idx, err, chk} !== '0) begin
      n_fail++; $display("FAIL reset_data: got data=%h idx=%0d err=%0d chk=%h expected zeros",
        byte_data, byte_idx, err, chk);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_readout();
    logic [7:0] bytes[$];
    bit ok;
    int base, n_rx, ss, sb;
    for (int sc = 0; sc < 2; sc++) begin
      bytes.delete();
      for (int i = 0; i < NB; i++) bytes.push_back(sc == 0 ? 8'(i) : 8'($urandom));
      base = rx_data_q.size(); ss = n_start; sb = n_sbf;
      capture(bytes, NB, 2, ok);
      n_rx = rx_data_q.size() - base;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL readout_handshake sc=%0d: got no start/sbf expected both", sc); end
      n_checks++;
      if (n_start - ss != 1 || n_sbf - sb != 1) begin
        n_fail++; $display("FAIL readout_pulses sc=%0d: got start=%0d sbf=%0d expected 1 1", sc, n_start - ss, n_sbf - sb);
      end
      n_checks++;
      if (n_rx != NB) begin n_fail++; $display("FAIL readout_count sc=%0d: got %0d expected %0d", sc, n_rx, NB); end
      for (int i = 0; i < n_rx && i < NB; i++) begin
        n_checks++;
        if (rx_data_q[base+i] !== bytes[i] || rx_idx_q[base+i] != i) begin
          n_fail++; $display("FAIL readout_byte sc=%0d i=%0d: got %h@%0d expected %h@%0d",
            sc, i, rx_data_q[base+i], rx_idx_q[base+i], bytes[i], i);
        end
      end
      n_checks++;
      if ({done, busy, tsc_bus.reset, err} !== {3'b101, ERR_NONE}) begin
        n_fail++; $display("FAIL readout_status sc=%0d: got done=%b busy=%b rst=%b err=%0d expected 1 0 1 0",
          sc, done, busy, tsc_bus.reset, err);
      end
      n_checks++;
      if (chk !== exp_chk(bytes, NB)) begin
        n_fail++; $display("FAIL readout_chk sc=%0d: got %h expected %h", sc, chk, exp_chk(bytes, NB));
      end
    end
  endtask

  task automatic test_zero_bits();
    logic [7:0] bytes[$];
    bit ok;
    int base, n_rx, bad;
    for (int i = 0; i < NB; i++) bytes.push_back((i % 2 == 0) ? 8'h00 : 8'h80);
    base = rx_data_q.size();
    capture(bytes, NB, 0, ok);
    n_rx = rx_data_q.size() - base;
    bad = 0;
    for (int i = 0; i < n_rx && i < NB; i++) if (rx_data_q[base+i] !== bytes[i]) bad++;
    n_checks++;
    if (!ok || n_rx != NB || bad != 0) begin
      n_fail++; $display("FAIL zero_bits: got count=%0d wrong=%0d expected count=%0d wrong=0", n_rx, bad, NB);
    end
    n_checks++;
    if (rx_data_q[base] !== 8'h00 || rx_data_q[base+1] !== 8'h80) begin
      n_fail++; $display("FAIL zero_bits_pair: got %h %h expected 00 80", rx_data_q[base], rx_data_q[base+1]);
    end
  endtask

  task automatic test_checksum();
    logic [7:0] bytes[$];
    logic [7:0] want;
    bit ok;
    for (int sc = 0; sc < 2; sc++) begin
      bytes.delete();
      for (int i = 0; i < NB; i++)
        bytes.push_back(sc == 0 ? 8'(i) : ((i == NB - 1) ? 8'h5A : 8'hA5));
`ifdef TSC_SEQ_CHECKSUM_EN
      want = (sc == 0) ? 8'h00 : 8'hFF;
`else
      want = 8'h00;
`endif
      capture(bytes, NB, 1, ok);
      n_checks++;
      if (!ok || chk !== want || done !== 1'b1) begin
        n_fail++; $display("FAIL checksum sc=%0d: got chk=%h done=%b expected chk=%h done=1", sc, chk, done, want);
      end
    end
  endtask

  task automatic test_early_cd();
    logic [7:0] bytes[$];
    bit ok;
    int base, n_rx;
    for (int i = 0; i < NB; i++) bytes.push_back(8'($urandom));
    base = rx_data_q.size();
    capture(bytes, 10, 2, ok);
    n_rx = rx_data_q.size() - base;
    n_checks++;
    if (!ok || n_rx != 10) begin n_fail++; $display("FAIL early_cd_count: got %0d expected 10", n_rx); end
    n_checks++;
    if (n_rx > 0 && rx_idx_q[base+n_rx-1] != 9) begin
      n_fail++; $display("FAIL early_cd_idx: got %0d expected 9", rx_idx_q[base+n_rx-1]);
    end
    n_checks++;
    if (err !== ERR_FRAME || done !== 1'b0 || tsc_bus.reset !== 1'b1) begin
      n_fail++; $display("FAIL early_cd_err: got err=%0d done=%b rst=%b expected 3 0 1", err, done, tsc_bus.reset);
    end
    n_checks++;
    if (chk !== exp_chk(bytes, 10)) begin
      n_fail++; $display("FAIL early_cd_chk: got %h expected %h", chk, exp_chk(bytes, 10));
    end
  endtask

  task automatic test_back_to_back();
    cmd_arm = 1'b1; tick(); cmd_arm = 1'b0;
    n_checks++;
    if ({done, busy, tsc_bus.reset, err, chk} !== {3'b010, ERR_NONE, 8'h00}) begin
      n_fail++; $display("FAIL rearm_clear: got done=%b busy=%b rst=%b err=%0d chk=%h expected 0 1 0 0 00",
        done, busy, tsc_bus.reset, err, chk);
    end
    repeat (6) tick();
    cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || err !== ERR_NONE) begin
      n_fail++; $display("FAIL rearm_abort: got busy=%b err=%0d expected 0 0", busy, err);
    end
  endtask

  task automatic test_trig_timeout();
    int n, sb;
    cmd_arm = 1'b1; tick(); cmd_arm = 1'b0;
    for (int i = 0; i < SG + 4 && !tsc_bus.start; i++) tick();
    sb = n_sbf;
    n = 0;
    while (err == ERR_NONE && n < TT + 20) begin tick(); n++; end
    tick();
    n_checks++;
    if (n != TT + 1) begin n_fail++; $display("FAIL trig_to_latency: got %0d expected %0d", n, TT + 1); end
    n_checks++;
    if (err !== ERR_TRIG_TO || tsc_bus.reset !== 1'b1 || busy !== 1'b0 || n_sbf != sb) begin
      n_fail++; $display("FAIL trig_to_state: got err=%0d rst=%b busy=%b sbf=%0d expected 1 1 0 0",
        err, tsc_bus.reset, busy, n_sbf - sb);
    end
  endtask

  task automatic test_xfer_timeout();
    int n;
    bit ok;
    start_cycle(5, ok);
    n = 0;
    tsc_bus.sd = 1'b1;
    while (ok && err == ERR_NONE && n < XT + 20) begin tick(); n++; end
    n_checks++;
    if (!ok || n != XT + 1) begin n_fail++; $display("FAIL xfer_to_latency: got %0d expected %0d", n, XT + 1); end
    n_checks++;
    if (err !== ERR_XFER_TO || tsc_bus.reset !== 1'b1) begin
      n_fail++; $display("FAIL xfer_to_state: got err=%0d rst=%b expected 2 1", err, tsc_bus.reset);
    end
  endtask

  task automatic test_abort();
    logic [7:0] bytes[$];
    bit ok;
    int base;
    base = rx_data_q.size();
    start_cycle(10, ok);
    idle(1);
    for (int k = 0; k < 5; k++) send_frame(8'h40 + 8'(k));
    tsc_bus.sd = 1'b0; tick();
    tsc_bus.sd = 1'b1; tick(); tick();
    cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
    n_checks++;
    if (!ok || busy !== 1'b0 || tsc_bus.reset !== 1'b1 || err !== ERR_NONE || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: got busy=%b rst=%b err=%0d done=%b expected 0 1 0 0",
        busy, tsc_bus.reset, err, done);
    end
    for (int i = 0; i < 20; i++) begin tsc_bus.sd = 1'($urandom); tick(); end
    idle(2);
    n_checks++;
    if (rx_data_q.size() - base != 5) begin
      n_fail++; $display("FAIL abort_strobes: got %0d expected 5", rx_data_q.size() - base);
    end
    for (int i = 0; i < NB; i++) bytes.push_back(8'($urandom));
    base = rx_data_q.size();
    capture(bytes, NB, 2, ok);
    n_checks++;
    if (!ok || done !== 1'b1 || rx_data_q.size() - base != NB || rx_data_q[base+NB-1] !== bytes[NB-1]) begin
      n_fail++; $display("FAIL abort_rearm: got done=%b count=%0d expected 1 %0d", done, rx_data_q.size() - base, NB);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bytes[$];
    bit ok;
    int base;
    start_cycle(3, ok);
    idle(1);
    send_frame(8'h11);
    send_frame(8'h22);
    tsc_bus.sd = 1'b0; tick();
    tsc_bus.sd = 1'b1; tick(); tick();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({tsc_bus.reset, tsc_bus.start, tsc_bus.sbf, byte_valid, busy, done} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_mid_ctrl: got %b expected 100000",
        {tsc_bus.reset, tsc_bus.start, tsc_bus.sbf, byte_valid, busy, done});
    end
    n_checks++;
    if ({byte_data, byte_idx, err, chk} !== '0) begin
      n_fail++; $display("FAIL reset_mid_data: got data=%h idx=%0d err=%0d chk=%h expected zeros",
        byte_data, byte_idx, err, chk);
    end
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < NB; i++) bytes.push_back(8'($urandom));
    base = rx_data_q.size();
    capture(bytes, NB, 2, ok);
    n_checks++;
    if (!ok || done !== 1'b1 || rx_data_q.size() - base != NB || rx_data_q[base] !== bytes[0]) begin
      n_fail++; $display("FAIL reset_mid_rerun: got done=%b count=%0d expected 1 %0d", done, rx_data_q.size() - base, NB);
    end
  endtask

  initial begin
    tsc_bus.trd = 1'b0;
    tsc_bus.cd  = 1'b0;
    tsc_bus.sd  = 1'b1;
    test_reset();
    test_readout();
    test_zero_bits();
    test_checksum();
    test_early_cd();
    test_back_to_back();
    test_trig_timeout();
    test_xfer_timeout();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
